// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: buffers one wide beat and replays its kept
// lanes, lowest lane first, as one narrow beat per cycle.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [T_DATA_RATIO-1:0]                    s_keep_i,
    input  logic                                       s_last_i,
    input  logic                                       s_valid_i,
    output logic                                       s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                    m_data_o,
    output logic                                       m_last_o,
    output logic                                       m_valid_o,
    input  logic                                       m_ready_i
);
    localparam int T_WIDTH_RATIO = $clog2(T_DATA_RATIO);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                                    r_state;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] r_buf;
    logic [T_DATA_RATIO-1:0]                   r_rem;
    logic                                      r_last;
    logic [T_DATA_WIDTH-1:0]                   r_mData;
    logic                                      r_mLast;

    logic                                      w_remOneHot;
    logic                                      w_inFire;
    logic                                      w_outFire;
    logic [T_DATA_RATIO-1:0]                   w_remNext;
    logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] w_bufNext;
    logic                                      w_lastNext;

    function automatic logic [T_WIDTH_RATIO-1:0] lowestSet(input logic [T_DATA_RATIO-1:0] mask);
        lowestSet = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (mask[i]) lowestSet = T_WIDTH_RATIO'(i);
        end
    endfunction

    function automatic logic isOneHot(input logic [T_DATA_RATIO-1:0] mask);
        isOneHot = (mask != '0) && ((mask & (mask - T_DATA_RATIO'(1))) == '0);
    endfunction

    // A new wide beat may enter in the same cycle the final buffered lane leaves.
    assign w_remOneHot = isOneHot(r_rem);
    assign s_ready_o   = !rst && ((r_state == IDLE) || (m_ready_i && w_remOneHot));
    assign w_inFire    = s_valid_i && s_ready_o;
    assign w_outFire   = (r_state == BUSY) && m_ready_i;

    always_comb begin
        w_remNext  = r_rem;
        w_bufNext  = r_buf;
        w_lastNext = r_last;
        if (w_outFire) begin
            w_remNext = r_rem & (r_rem - T_DATA_RATIO'(1));
        end
        if (w_inFire) begin
            w_remNext  = s_keep_i;
            w_bufNext  = s_data_i;
            w_lastNext = s_last_i;
        end
    end

    // Output lane and last flag are precomputed from the next mask so m_* come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_last  <= 1'b0;
            r_mLast <= 1'b0;
        end else begin
            r_buf   <= w_bufNext;
            r_rem   <= w_remNext;
            r_last  <= w_lastNext;
            r_state <= (w_remNext != '0) ? BUSY : IDLE;
            r_mData <= w_bufNext[lowestSet(w_remNext)];
            r_mLast <= w_lastNext && isOneHot(w_remNext);
        end
    end

    assign m_valid_o = (r_state == BUSY);
    assign m_data_o  = r_mData;
    assign m_last_o  = r_mLast;

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: vector table, hand-written corner
// sequences and a random run, all backed by a kept-lane scoreboard queue.
module tb_stream_downsize;
    localparam int W = 8;
    localparam int R = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [R-1:0][W-1:0] sData;
    logic [R-1:0]      sKeep;
    logic              sLast;
    logic              sValid;
    logic              sReady;
    logic [W-1:0]      mData;
    logic              mLast;
    logic              mValid;
    logic              mReady;

    int nCompared   = 0;
    int nMismatched = 0;
    int lastSent    = 0;
    int lastSeen    = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t sbQueue[$];

    typedef struct {
        logic [R-1:0][W-1:0] data;
        logic [R-1:0]        keep;
        logic                last;
        int                  nOut;
        logic [R-1:0][W-1:0] expData;
        logic [R-1:0]        expLast;
    } vector_t;

    vector_t vectors[6];

    logic         prevStall = 1'b0;
    logic [W-1:0] prevData;
    logic         prevLast;

    stream_downsize #(
        .T_DATA_WIDTH(W),
        .T_DATA_RATIO(R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data_i (sData),
        .s_keep_i (sKeep),
        .s_last_i (sLast),
        .s_valid_i(sValid),
        .s_ready_o(sReady),
        .m_data_o (mData),
        .m_last_o (mLast),
        .m_valid_o(mValid),
        .m_ready_i(mReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted beats push their kept lanes, output handshakes pop and compare.
    always @(negedge clk) begin
        beat_t e;
        int    lastIdx;
        if (rst) begin
            sbQueue.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallValid", mValid, 1);
                checkOutput("stallData", mData, prevData);
                checkOutput("stallLast", mLast, prevLast);
            end
            if (mValid && mReady) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sbUnexpectedBeat", 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("sbData", mData, e.data);
                    checkOutput("sbLast", mLast, e.last);
                end
                if (mLast) lastSeen++;
            end
            if (sValid && sReady) begin
                lastIdx = -1;
                for (int i = 0; i < R; i++) if (sKeep[i]) lastIdx = i;
                for (int i = 0; i < R; i++) begin
                    if (sKeep[i]) sbQueue.push_back({sData[i], sLast && (i == lastIdx)});
                end
                if (sLast && (sKeep != '0)) lastSent++;
            end
            prevStall = mValid && !mReady;
            prevData  = mData;
            prevLast  = mLast;
        end
    end

    task automatic applyStimulus(input logic [R-1:0][W-1:0] data, input logic [R-1:0] keep, input logic last);
        logic accepted;
        accepted = 1'b0;
        sData  = data;
        sKeep  = keep;
        sLast  = last;
        sValid = 1'b1;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            accepted = sReady;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("acceptTimeout", 0, 1);
        sValid = 1'b0;
    endtask

    task automatic expectBeat(input string name, input logic [W-1:0] data, input logic last, input logic ready);
        @(negedge clk);
        checkOutput({name, ".valid"}, mValid, 1);
        checkOutput({name, ".data"}, mData, data);
        checkOutput({name, ".last"}, mLast, last);
        checkOutput({name, ".ready"}, sReady, ready);
        @(posedge clk);
        #1;
    endtask

    task automatic expectIdle(input string name);
        @(negedge clk);
        checkOutput(name, mValid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic accepted;
        logic drained;

        vectors[0] = '{{8'd44, 8'd33, 8'd22, 8'd11}, 4'b1111, 1'b1, 4, {8'd44, 8'd33, 8'd22, 8'd11}, 4'b1000};
        vectors[1] = '{{8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4'b1010, 1'b0, 2, {8'h00, 8'h00, 8'hA3, 8'hA1}, 4'b0000};
        vectors[2] = '{{8'h01, 8'h02, 8'h03, 8'h04}, 4'b0000, 1'b1, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000};
        vectors[3] = '{{8'hBB, 8'hBB, 8'hB1, 8'hB0}, 4'b0011, 1'b1, 2, {8'h00, 8'h00, 8'hB1, 8'hB0}, 4'b0010};
        vectors[4] = '{{8'hC3, 8'hC2, 8'hC1, 8'hC0}, 4'b0100, 1'b1, 1, {8'h00, 8'h00, 8'h00, 8'hC2}, 4'b0001};
        vectors[5] = '{{8'hD3, 8'hD2, 8'hD1, 8'hD0}, 4'b1001, 1'b0, 2, {8'h00, 8'h00, 8'hD3, 8'hD0}, 4'b0000};

        rst    = 1'b1;
        sValid = 1'b0;
        sData  = '0;
        sKeep  = '0;
        sLast  = 1'b0;
        mReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReady", sReady, 0);
        checkOutput("resetValid", mValid, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mReady = 1'b1;
        @(negedge clk);
        checkOutput("postResetReady", sReady, 1);
        checkOutput("postResetValid", mValid, 0);
        @(posedge clk);
        #1;

        // Table: each vector is one wide beat, outputs expected on consecutive cycles.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vectors[v].data, vectors[v].keep, vectors[v].last);
            for (int k = 0; k < vectors[v].nOut; k++) begin
                expectBeat($sformatf("vec%0d.beat%0d", v, k), vectors[v].expData[k],
                           vectors[v].expLast[k], k == vectors[v].nOut - 1);
            end
            expectIdle($sformatf("vec%0d.idleAfter", v));
        end

        // Sparse beat followed immediately by a single-lane beat: no gap expected.
        applyStimulus({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 4'b1010, 1'b0);
        sData  = {8'h0B, 8'h0B, 8'h0B, 8'hB0};
        sKeep  = 4'b0001;
        sLast  = 1'b1;
        sValid = 1'b1;
        expectBeat("b2b.A1", 8'hA1, 1'b0, 1'b0);
        expectBeat("b2b.A3", 8'hA3, 1'b0, 1'b1);
        sValid = 1'b0;
        expectBeat("b2b.B0", 8'hB0, 1'b1, 1'b1);
        expectIdle("b2b.idleAfter");

        // Backpressure: lane 0 must hold while the sink stalls.
        applyStimulus({8'hE3, 8'hE2, 8'hE1, 8'hE0}, 4'b1111, 1'b1);
        mReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expectBeat($sformatf("stall%0d", c), 8'hE0, 1'b0, 1'b0);
        end
        mReady = 1'b1;
        expectBeat("release.E0", 8'hE0, 1'b0, 1'b0);
        expectBeat("release.E1", 8'hE1, 1'b0, 1'b0);
        expectBeat("release.E2", 8'hE2, 1'b0, 1'b0);
        expectBeat("release.E3", 8'hE3, 1'b1, 1'b1);
        expectIdle("release.idleAfter");

        // Reset after one lane of a four-lane beat has gone out.
        applyStimulus({8'hF3, 8'hF2, 8'hF1, 8'hF0}, 4'b1111, 1'b1);
        expectBeat("midReset.F0", 8'hF0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset.readyInReset", sReady, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReset.validAfter", mValid, 0);
        checkOutput("midReset.readyAfter", sReady, 1);
        @(posedge clk);
        #1;
        applyStimulus({8'h63, 8'h62, 8'h61, 8'h60}, 4'b1111, 1'b0);
        expectBeat("midReset.G0", 8'h60, 1'b0, 1'b0);
        expectBeat("midReset.G1", 8'h61, 1'b0, 1'b0);
        expectBeat("midReset.G2", 8'h62, 1'b0, 1'b0);
        expectBeat("midReset.G3", 8'h63, 1'b0, 1'b1);
        expectIdle("midReset.idleAfter");

        // Random traffic with source hold and sink stalls, checked by the scoreboard.
        lastSent = 0;
        lastSeen = 0;
        accepted = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            accepted = sValid && sReady;
            @(posedge clk);
            #1;
            if (!sValid || accepted) begin
                sValid = 1'($urandom_range(0, 1));
                sData  = $urandom;
                sKeep  = 4'($urandom_range(0, 15));
                sLast  = 1'($urandom_range(0, 1));
            end
            mReady = ($urandom_range(0, 3) != 0);
        end
        sValid  = 1'b0;
        mReady  = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(negedge clk);
            if (!mValid) drained = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("random.drained", drained, 1);
        checkOutput("random.queueEmpty", sbQueue.size(), 0);
        checkOutput("random.lastCount", lastSeen, lastSent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
